// File: rtl/subtractor8bit_serial_if.sv
// Handshake and operand/result bundle for the bit-serial 8-bit subtractor.
interface subtractor8bit_serial_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       overflow;

  modport master (output start, a, b, input busy, done, diff, borrow, overflow);
  modport slave  (input start, a, b, output busy, done, diff, borrow, overflow);
endinterface

// File: rtl/subtractor8bit_serial.sv
// Bit-serial 8-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional SUB_SATURATE_EN clamps diff to 0x7F/0x80 on signed overflow.
module subtractor8bit_serial (
  input  logic                      clk,
  input  logic                      reset,
  subtractor8bit_serial_if.slave    sub
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_nx;
  logic [7:0] a_sr, b_sr, res_sr;
  logic       bor;
  logic [2:0] cnt;
  logic [7:0] diff_q;
  logic       borrow_q, overflow_q;

  logic       accept, last, d, bor_nx, ovf_nx;
  logic [7:0] raw, res_out;
  logic       busy_c, done_c;

  // Single full-subtractor cell; at bit 7 the operand LSBs are the original sign bits.
  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    d      = a_sr[0] ^ b_sr[0] ^ bor;
    bor_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
    raw    = {d, res_sr[7:1]};
    ovf_nx = (a_sr[0] != b_sr[0]) && (raw[7] != a_sr[0]);
    if (sub.start && state != RUN) accept = 1'b1;
    if (state == RUN && cnt == 3'd7) last = 1'b1;
`ifdef SUB_SATURATE_EN
    res_out = ovf_nx ? (a_sr[0] ? 8'h80 : 8'h7F) : raw;
`else
    res_out = raw;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (sub.start) state_nx = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (cnt == 3'd7) state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = sub.start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr       <= 8'h00;
      b_sr       <= 8'h00;
      res_sr     <= 8'h00;
      bor        <= 1'b0;
      cnt        <= 3'd0;
      diff_q     <= 8'h00;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        a_sr   <= sub.a;
        b_sr   <= sub.b;
        res_sr <= 8'h00;
        bor    <= 1'b0;
        cnt    <= 3'd0;
      end else if (state == RUN) begin
        a_sr   <= {1'b0, a_sr[7:1]};
        b_sr   <= {1'b0, b_sr[7:1]};
        res_sr <= raw;
        bor    <= bor_nx;
        cnt    <= cnt + 3'd1;
      end
      // Visible results move only when an operation completes.
      if (last) begin
        diff_q     <= res_out;
        borrow_q   <= bor_nx;
        overflow_q <= ovf_nx;
      end
    end
  end

  assign sub.busy     = busy_c;
  assign sub.done     = done_c;
  assign sub.diff     = diff_q;
  assign sub.borrow   = borrow_q;
  assign sub.overflow = overflow_q;

endmodule

// File: tb/tb_subtractor8bit_serial.sv
// Randomized self-checking bench for subtractor8bit_serial against an arithmetic reference.
module tb_subtractor8bit_serial;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  subtractor8bit_serial_if sub_if ();

  subtractor8bit_serial dut (
    .clk   (clk),
    .reset (reset),
    .sub   (sub_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {borrow, overflow, diff} from plain integer arithmetic.
  function automatic logic [9:0] ref_sub(input logic [7:0] av, input logic [7:0] bv);
    int ua, ub, sa, sb, sd;
    logic [7:0] dv;
    logic bw, ov;
    ua = int'(av);
    ub = int'(bv);
    sa = av[7] ? ua - 256 : ua;
    sb = bv[7] ? ub - 256 : ub;
    sd = sa - sb;
    dv = 8'((ua - ub + 256) % 256);
    bw = (ua < ub);
    ov = (sd > 127) || (sd < -128);
`ifdef SUB_SATURATE_EN
    if (ov) dv = (sd > 127) ? 8'h7F : 8'h80;
`endif
    return {bw, ov, dv};
  endfunction

  task automatic check_result(input string tag, input logic [9:0] e);
    chk({tag, " done"},     32'(sub_if.done),     32'd1);
    chk({tag, " busy@done"},32'(sub_if.busy),     32'd0);
    chk({tag, " diff"},     32'(sub_if.diff),     32'(e[7:0]));
    chk({tag, " borrow"},   32'(sub_if.borrow),   32'(e[9]));
    chk({tag, " overflow"}, 32'(sub_if.overflow), 32'(e[8]));
  endtask

  // Starts from idle/done, waits bounded for done, checks latency, hold and results.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
    logic [9:0] e;
    logic [7:0] pd;
    int cyc;
    e  = ref_sub(av, bv);
    pd = sub_if.diff;
    @(negedge clk);
    sub_if.start = 1'b1; sub_if.a = av; sub_if.b = bv;
    @(negedge clk);
    sub_if.start = 1'b0; sub_if.a = 8'($urandom); sub_if.b = 8'($urandom);
    chk({tag, " busy"}, 32'(sub_if.busy), 32'd1);
    cyc = 0;
    while (!sub_if.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) chk({tag, " hold"}, 32'(sub_if.diff), 32'(pd));
    end
    chk({tag, " latency"}, 32'(cyc), 32'd8);
    check_result(tag, e);
  endtask

  initial begin
    logic [9:0] e;
    int cyc;
    reset = 1'b1;
    sub_if.start = 1'b0; sub_if.a = 8'h00; sub_if.b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst busy",     32'(sub_if.busy),     32'd0);
    chk("rst done",     32'(sub_if.done),     32'd0);
    chk("rst diff",     32'(sub_if.diff),     32'd0);
    chk("rst borrow",   32'(sub_if.borrow),   32'd0);
    chk("rst overflow", 32'(sub_if.overflow), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle busy", 32'(sub_if.busy), 32'd0);
      chk("idle done", 32'(sub_if.done), 32'd0);
    end

    run_op(8'h05, 8'h03, "05-03");
    @(negedge clk);
    chk("pulse done", 32'(sub_if.done), 32'd0);
    chk("pulse busy", 32'(sub_if.busy), 32'd0);
    run_op(8'h03, 8'h05, "03-05");
    run_op(8'h80, 8'h01, "80-01");
    run_op(8'h7F, 8'hFF, "7F-FF");

    // Ignored start mid-RUN, then back-to-back start in the done cycle.
    e = ref_sub(8'h10, 8'h01);
    @(negedge clk);
    sub_if.start = 1'b1; sub_if.a = 8'h10; sub_if.b = 8'h01;
    @(negedge clk);
    sub_if.start = 1'b0;
    repeat (2) @(negedge clk);
    sub_if.start = 1'b1; sub_if.a = 8'h00; sub_if.b = 8'h00;
    @(negedge clk);
    sub_if.start = 1'b0;
    chk("ign busy", 32'(sub_if.busy), 32'd1);
    cyc = 3;
    while (!sub_if.done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("ign latency", 32'(cyc), 32'd8);
    check_result("10-01", e);
    sub_if.start = 1'b1; sub_if.a = 8'h20; sub_if.b = 8'h20;
    @(negedge clk);
    sub_if.start = 1'b0;
    chk("b2b busy", 32'(sub_if.busy), 32'd1);
    chk("b2b done", 32'(sub_if.done), 32'd0);
    chk("b2b hold", 32'(sub_if.diff), 32'h0F);
    cyc = 1;
    while (!sub_if.done && cyc < 20) begin
      chk("b2b excl", 32'(sub_if.busy & sub_if.done), 32'd0);
      @(negedge clk); cyc++;
    end
    chk("b2b period", 32'(cyc), 32'd9);
    check_result("20-20", ref_sub(8'h20, 8'h20));

    // Reset after 4 bits of a run.
    run_op(8'h03, 8'h05, "pre-rst");
    @(negedge clk);
    sub_if.start = 1'b1; sub_if.a = 8'h55; sub_if.b = 8'h11;
    @(negedge clk);
    sub_if.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid busy",     32'(sub_if.busy),     32'd0);
    chk("mid done",     32'(sub_if.done),     32'd0);
    chk("mid diff",     32'(sub_if.diff),     32'd0);
    chk("mid borrow",   32'(sub_if.borrow),   32'd0);
    chk("mid overflow", 32'(sub_if.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post busy", 32'(sub_if.busy), 32'd0);
    run_op(8'hFF, 8'h01, "FF-01");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 8 == 0) rb = ra ^ 8'h80;
      run_op(ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
